// File: rtl/calc_controller.sv
// Sequencing controller for a small accumulate datapath: accepts LOAD/ADD/SUB/CLEAR
// requests and issues HOLD/CAPTURE/ADD/SUB commands, repeating ADD/SUB count+1 times.
module calc_controller #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CNT_WIDTH = 3
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [WIDTH-1:0]     req_data,
    input  logic [CNT_WIDTH-1:0] req_count,
    output logic [2:0]           cmd,
    output logic [WIDTH-1:0]     d_out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam logic [2:0] CMD_HOLD    = 3'b000;
    localparam logic [2:0] CMD_CAPTURE = 3'b001;
    localparam logic [2:0] CMD_ADD     = 3'b010;
    localparam logic [2:0] CMD_SUB     = 3'b100;

    state_e               state_q, state_d;
    logic [2:0]           op_cmd_q, op_cmd_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [2:0]           cmd_q, cmd_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d  = state_q;
        op_cmd_d = op_cmd_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_EXEC;
                    data_d  = req_data;
                    cnt_d   = req_count;
                    case (req_op)
                        2'b00:   op_cmd_d = CMD_CAPTURE;
                        2'b01:   op_cmd_d = CMD_ADD;
                        2'b10:   op_cmd_d = CMD_SUB;
                        default: begin
                            op_cmd_d = CMD_CAPTURE;
                            data_d   = '0;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                // CAPTURE is single-shot; repeated ops exit when the counter reads zero
                if (op_cmd_q == CMD_CAPTURE || cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so decode them from the state being entered
        ready_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        cmd_d   = CMD_HOLD;
        case (state_d)
            S_EXEC:  cmd_d = op_cmd_d;
            S_DONE:  done_d = 1'b1;
            default: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_cmd_q <= CMD_HOLD;
            cnt_q    <= '0;
            data_q   <= '0;
            cmd_q    <= CMD_HOLD;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_cmd_q <= op_cmd_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            cmd_q    <= cmd_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign req_ready = ready_q;
    assign cmd       = cmd_q;
    assign d_out     = data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
